// File: rtl/exception_ctrl.sv
// exception_ctrl: multi-source, nesting exception controller for the pipelined
// LEGv8 core. Arbitrates prioritised requests (index 0 highest), redirects
// fetch to a per-cause vector, keeps return state on a small stack and
// restores it on ERET.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-low reset
//   exc_req       level request per source
//   eret          ERET in E stage (one-cycle pulse)
//   imem_addr_F   current fetch address (saved as ELR)
//   next_pc_F     sequential next PC (saved as ERR, the return target)
//   pcbranch_E    normal branch target from E
//   estatus       status captured with the exception
//   sysreg_sel    system-register select for MRS
//   eproc         exception in progress (flush/redirect)
//   exc_ack       fetch has reached the vector
//   evaddr_F      vector address of the latched cause
//   pcbranch      branch target to the PC mux
//   sysreg_rdata  system-register read data
//   depth         stack occupancy
//   overflow      sticky: a request was refused because the stack was full
//
// state | meaning
// RUN   | normal execution; accepts requests and ERET
// REDIR | fetch is being steered to the vector; waits for exc_ack

module exception_ctrl #(
    parameter int ADDR_W   = 64,
    parameter int NUM_SRC  = 4,
    parameter int DEPTH    = 2,
    parameter int STATUS_W = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 64'hD8,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 64'h80,
    localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  exc_req,
    input  logic                eret,
    input  logic [ADDR_W-1:0]   imem_addr_F,
    input  logic [ADDR_W-1:0]   next_pc_F,
    input  logic [ADDR_W-1:0]   pcbranch_E,
    input  logic [STATUS_W-1:0] estatus,
    input  logic [1:0]          sysreg_sel,
    output logic                eproc,
    output logic                exc_ack,
    output logic [ADDR_W-1:0]   evaddr_F,
    output logic [ADDR_W-1:0]   pcbranch,
    output logic [ADDR_W-1:0]   sysreg_rdata,
    output logic [DW-1:0]       depth,
    output logic                overflow
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, REDIR} state_t;

    state_t              state;
    logic [CW-1:0]       cause_q;
    logic [ADDR_W-1:0]   elr_stk    [DEPTH];
    logic [ADDR_W-1:0]   err_stk    [DEPTH];
    logic [CW-1:0]       cause_stk  [DEPTH];
    logic [STATUS_W-1:0] status_stk [DEPTH];

    logic [IW-1:0]       top_idx;
    logic [IW-1:0]       push_idx;
    logic [CW-1:0]       top_cause;
    logic [NUM_SRC-1:0]  elig;
    logic                any_elig;
    logic [CW-1:0]       win;
    logic                stk_empty;
    logic                stk_full;
    logic                do_pop;
    logic                do_push;
    logic                do_ovf;

    // Top index is only meaningful when the stack is non-empty; every read
    // through it is qualified by stk_empty.
    assign top_idx   = IW'(depth - DW'(1));
    assign push_idx  = IW'(depth);
    assign stk_empty = (depth == '0);
    assign stk_full  = (depth == DW'(DEPTH));
    assign top_cause = cause_stk[top_idx];

    // Nesting: with handlers active only strictly higher-priority causes win.
    always_comb begin
        elig     = '0;
        win      = '0;
        any_elig = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = exc_req[i] && (stk_empty || (CW'(i) < top_cause));
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win      = CW'(i);
                any_elig = 1'b1;
            end
        end
    end

    // ERET outranks a simultaneous request; the request is re-judged against
    // the popped stack on the next cycle.
    assign do_pop  = (state == RUN) && eret && !stk_empty;
    assign do_push = (state == RUN) && !eret && any_elig && !stk_full;
    assign do_ovf  = (state == RUN) && !eret && any_elig && stk_full;

    assign evaddr_F = VEC_BASE + ADDR_W'(cause_q) * VEC_STRIDE;
    assign exc_ack  = (state == REDIR) && (imem_addr_F == evaddr_F);
    assign pcbranch = do_pop ? err_stk[top_idx] : pcbranch_E;

    always_comb begin
        sysreg_rdata = '0;
        unique case (sysreg_sel)
            2'd0: if (!stk_empty) sysreg_rdata = err_stk[top_idx];
            2'd1: if (!stk_empty) sysreg_rdata = elr_stk[top_idx];
            2'd2: if (!stk_empty) sysreg_rdata = ADDR_W'({cause_stk[top_idx], status_stk[top_idx]});
            2'd3: sysreg_rdata = ADDR_W'(depth);
            default: sysreg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            cause_q  <= '0;
            depth    <= '0;
            overflow <= 1'b0;
            eproc    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                elr_stk[i]    <= '0;
                err_stk[i]    <= '0;
                cause_stk[i]  <= '0;
                status_stk[i] <= '0;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (do_pop) begin
                        depth <= depth - DW'(1);
                    end else if (do_push) begin
                        elr_stk[push_idx]    <= imem_addr_F;
                        err_stk[push_idx]    <= next_pc_F;
                        cause_stk[push_idx]  <= win;
                        status_stk[push_idx] <= estatus;
                        cause_q              <= win;
                        depth                <= depth + DW'(1);
                        eproc                <= 1'b1;
                        state                <= REDIR;
                    end else if (do_ovf) begin
                        overflow <= 1'b1;
                    end
                end
                REDIR: begin
                    if (exc_ack) begin
                        eproc <= 1'b0;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

    localparam logic [63:0] PCB_E = 64'hBEEF;

    logic        clk;
    logic        reset;
    logic [3:0]  exc_req;
    logic        eret;
    logic [63:0] imem_addr_F;
    logic [63:0] next_pc_F;
    logic [63:0] pcbranch_E;
    logic [3:0]  estatus;
    logic [1:0]  sysreg_sel;
    logic        eproc;
    logic        exc_ack;
    logic [63:0] evaddr_F;
    logic [63:0] pcbranch;
    logic [63:0] sysreg_rdata;
    logic [1:0]  depth;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic        eproc;
        logic        ack;
        logic [63:0] ev;
        logic [63:0] pcb;
        logic [1:0]  dep;
        logic        ovf;
        logic [63:0] sys;
    } exp_t;

    exp_t sb[$];
    int   step_no = 0;

    exception_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .exc_req      (exc_req),
        .eret         (eret),
        .imem_addr_F  (imem_addr_F),
        .next_pc_F    (next_pc_F),
        .pcbranch_E   (pcbranch_E),
        .estatus      (estatus),
        .sysreg_sel   (sysreg_sel),
        .eproc        (eproc),
        .exc_ack      (exc_ack),
        .evaddr_F     (evaddr_F),
        .pcbranch     (pcbranch),
        .sysreg_rdata (sysreg_rdata),
        .depth        (depth),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue the
    // outputs expected during that cycle.
    task automatic step(input logic rst, input logic [3:0] req, input logic er,
                        input logic [63:0] imem, input logic [63:0] npc,
                        input logic [3:0] st, input logic [1:0] sel,
                        input logic e_proc, input logic e_ack, input logic [63:0] e_ev,
                        input logic [63:0] e_pcb, input logic [1:0] e_dep,
                        input logic e_ovf, input logic [63:0] e_sys);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        exc_req     = req;
        eret        = er;
        imem_addr_F = imem;
        next_pc_F   = npc;
        estatus     = st;
        sysreg_sel  = sel;
        step_no++;
        e.idx   = step_no;
        e.eproc = e_proc;
        e.ack   = e_ack;
        e.ev    = e_ev;
        e.pcb   = e_pcb;
        e.dep   = e_dep;
        e.ovf   = e_ovf;
        e.sys   = e_sys;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val($sformatf("s%0d_eproc", e.idx), {63'd0, eproc}, {63'd0, e.eproc});
            check_val($sformatf("s%0d_exc_ack", e.idx), {63'd0, exc_ack}, {63'd0, e.ack});
            check_val($sformatf("s%0d_evaddr", e.idx), evaddr_F, e.ev);
            check_val($sformatf("s%0d_pcbranch", e.idx), pcbranch, e.pcb);
            check_val($sformatf("s%0d_depth", e.idx), {62'd0, depth}, {62'd0, e.dep});
            check_val($sformatf("s%0d_overflow", e.idx), {63'd0, overflow}, {63'd0, e.ovf});
            check_val($sformatf("s%0d_sysreg", e.idx), sysreg_rdata, e.sys);
        end
    end

    initial begin
        reset       = 1'b0;
        exc_req     = '0;
        eret        = 1'b0;
        imem_addr_F = '0;
        next_pc_F   = '0;
        pcbranch_E  = PCB_E;
        estatus     = '0;
        sysreg_sel  = '0;

        //   rst  req     er  imem    npc     st sel   proc ack ev      pcb     dep ovf sys
        step(0, 4'b0000, 0, 64'h0,   64'h0,   0, 0,    0,  0, 64'hD8,  PCB_E,  0,  0, 64'h0);
        // cause 2 accepted; handler entry and ack
        step(1, 4'b0100, 0, 64'h40,  64'h44,  3, 0,    0,  0, 64'hD8,  PCB_E,  0,  0, 64'h0);
        step(1, 4'b0100, 0, 64'h1D4, 64'h1D8, 3, 0,    1,  0, 64'h1D8, PCB_E,  1,  0, 64'h44);
        step(1, 4'b0000, 0, 64'h1D8, 64'h1DC, 3, 1,    1,  1, 64'h1D8, PCB_E,  1,  0, 64'h40);
        // sustained cause 2 and lower-priority cause 3 ignored
        step(1, 4'b0100, 0, 64'h1DC, 64'h1E0, 3, 2,    0,  0, 64'h1D8, PCB_E,  1,  0, 64'h23);
        step(1, 4'b1000, 0, 64'h1E0, 64'h1E4, 3, 3,    0,  0, 64'h1D8, PCB_E,  1,  0, 64'h1);
        // cause 0 nests
        step(1, 4'b0001, 0, 64'h200, 64'h204, 5, 3,    0,  0, 64'h1D8, PCB_E,  1,  0, 64'h1);
        step(1, 4'b0000, 0, 64'h300, 64'h304, 5, 2,    1,  0, 64'hD8,  PCB_E,  2,  0, 64'h5);
        step(1, 4'b0000, 0, 64'hD8,  64'hDC,  5, 0,    1,  1, 64'hD8,  PCB_E,  2,  0, 64'h204);
        // ERET at depth 2 returns to inner ERR
        step(1, 4'b0000, 1, 64'hDC,  64'hE0,  5, 0,    0,  0, 64'hD8,  64'h204, 2, 0, 64'h204);
        step(1, 4'b0000, 0, 64'h204, 64'h208, 5, 0,    0,  0, 64'hD8,  PCB_E,  1,  0, 64'h44);
        // ERET with simultaneous request: pop first, accept next cycle
        step(1, 4'b0001, 1, 64'h300, 64'h304, 5, 3,    0,  0, 64'hD8,  64'h44, 1,  0, 64'h1);
        step(1, 4'b0001, 0, 64'h300, 64'h304, 5, 3,    0,  0, 64'hD8,  PCB_E,  0,  0, 64'h0);
        step(1, 4'b0000, 0, 64'h310, 64'h314, 5, 0,    1,  0, 64'hD8,  PCB_E,  1,  0, 64'h304);
        step(1, 4'b0000, 0, 64'hD8,  64'hDC,  5, 0,    1,  1, 64'hD8,  PCB_E,  1,  0, 64'h304);
        step(1, 4'b0000, 1, 64'hDC,  64'hE0,  5, 0,    0,  0, 64'hD8,  64'h304, 1, 0, 64'h304);
        // simultaneous 1010 -> cause 1
        step(1, 4'b1010, 0, 64'h500, 64'h504, 3, 3,    0,  0, 64'hD8,  PCB_E,  0,  0, 64'h0);
        step(1, 4'b1010, 0, 64'h510, 64'h514, 3, 2,    1,  0, 64'h158, PCB_E,  1,  0, 64'h13);
        step(1, 4'b1010, 0, 64'h158, 64'h15C, 3, 3,    1,  1, 64'h158, PCB_E,  1,  0, 64'h1);
        step(1, 4'b0000, 1, 64'h15C, 64'h160, 3, 3,    0,  0, 64'h158, 64'h504, 1, 0, 64'h1);
        // fill stack with causes 3 then 2, then cause 0 overflows
        step(1, 4'b1000, 0, 64'h600, 64'h604, 3, 3,    0,  0, 64'h158, PCB_E,  0,  0, 64'h0);
        step(1, 4'b0000, 0, 64'h258, 64'h25C, 3, 2,    1,  1, 64'h258, PCB_E,  1,  0, 64'h33);
        step(1, 4'b0100, 0, 64'h700, 64'h704, 3, 3,    0,  0, 64'h258, PCB_E,  1,  0, 64'h1);
        step(1, 4'b0000, 0, 64'h1D8, 64'h1DC, 3, 0,    1,  1, 64'h1D8, PCB_E,  2,  0, 64'h704);
        step(1, 4'b0001, 0, 64'h710, 64'h714, 3, 3,    0,  0, 64'h1D8, PCB_E,  2,  0, 64'h2);
        step(1, 4'b0000, 0, 64'h714, 64'h718, 3, 0,    0,  0, 64'h1D8, PCB_E,  2,  1, 64'h704);
        step(1, 4'b0000, 1, 64'h718, 64'h71C, 3, 1,    0,  0, 64'h1D8, 64'h704, 2, 1, 64'h700);
        step(1, 4'b0000, 0, 64'h704, 64'h708, 3, 2,    0,  0, 64'h1D8, PCB_E,  1,  1, 64'h33);
        step(1, 4'b0000, 1, 64'h708, 64'h70C, 3, 0,    0,  0, 64'h1D8, 64'h604, 1, 1, 64'h604);
        // ERET at depth 0 ignored; overflow stays set
        step(1, 4'b0000, 1, 64'h604, 64'h608, 3, 0,    0,  0, 64'h1D8, PCB_E,  0,  1, 64'h0);
        // reset asserted while in REDIR
        step(1, 4'b0010, 0, 64'h800, 64'h804, 3, 0,    0,  0, 64'h1D8, PCB_E,  0,  1, 64'h0);
        step(1, 4'b0000, 0, 64'h810, 64'h814, 3, 0,    1,  0, 64'h158, PCB_E,  1,  1, 64'h804);
        step(0, 4'b0000, 0, 64'hD8,  64'hDC,  3, 0,    0,  0, 64'hD8,  PCB_E,  0,  0, 64'h0);
        step(1, 4'b0000, 0, 64'hD8,  64'hDC,  3, 1,    0,  0, 64'hD8,  PCB_E,  0,  0, 64'h0);
        step(1, 4'b0000, 0, 64'hDC,  64'hE0,  3, 3,    0,  0, 64'hD8,  PCB_E,  0,  0, 64'h0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Multi-source, nesting exception controller for the pipelined LEGv8 core; successor to the single-source exception unit. Arbitrates `NUM_SRC` prioritised requests, redirects fetch to a per-cause vector, saves return state on a `DEPTH`-entry stack, and restores it on ERET. Sits beside the fetch/execute stages: it drives the fetch redirect address, the branch-target override, and the system-register read port used by MRS.

## Interface
- `ADDR_W`, 64, PC/address width
- `NUM_SRC`, 4, exception sources; index 0 is highest priority
- `DEPTH`, 2, maximum nesting depth (≥1)
- `STATUS_W`, 4, width of `estatus`
- `VEC_BASE`, 64'hD8, vector address of cause 0
- `VEC_STRIDE`, 64'h80, spacing between cause vectors
- Derived: `CW = max(1, $clog2(NUM_SRC))`; `DW = $clog2(DEPTH+1)`

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `exc_req` in NUM_SRC: level request per source
- `eret` in 1: ERET in E stage, one-cycle pulse
- `imem_addr_F` in ADDR_W: current fetch address
- `next_pc_F` in ADDR_W: sequential next PC in F
- `pcbranch_E` in ADDR_W: normal branch target from E
- `estatus` in STATUS_W: status captured with the exception
- `sysreg_sel` in 2: system-register select (instruction bits [13:12])
- `eproc` out 1: exception in progress; flush/redirect
- `exc_ack` out 1: fetch has reached the vector
- `evaddr_F` out ADDR_W: vector address for the latched cause
- `pcbranch` out ADDR_W: branch target to the PC mux
- `sysreg_rdata` out ADDR_W: system-register read data
- `depth` out DW: current stack occupancy
- `overflow` out 1: sticky; request refused because the stack was full

## Operation
- FSM states: RUN, REDIR. Reset state is RUN.
- Eligible sources:
  - `depth==0`: any bit of `exc_req`.
  - `depth>0`: only indices strictly below the top-of-stack cause (higher priority nests; equal or lower waits).
- RUN, eligible request, no `eret`, `depth<DEPTH`:
  - winner = lowest eligible index.
  - Push {ELR=`imem_addr_F`, ERR=`next_pc_F`, ESR={cause, `estatus`}}.
  - Latch cause; `depth`+1; go to REDIR.
- RUN, eligible request, `depth==DEPTH`: no push, no state change; `overflow` set (cleared only by reset).
- REDIR:
  - `eproc`=1.
  - `exc_ack` = (`imem_addr_F == evaddr_F`), combinational.
  - On `exc_ack` → RUN. Requests are ignored in REDIR.
- `evaddr_F = VEC_BASE + cause*VEC_STRIDE`, truncated modulo 2^ADDR_W.
- `eret` in RUN with `depth>0`:
  - `pcbranch` = top ERR.
  - Pop at the edge; `depth`−1.
  - `eret` has priority over a simultaneous request; the request is re-evaluated next cycle against the popped stack.
- `eret` with `depth==0`, or in REDIR: ignored; `pcbranch=pcbranch_E`.
- Otherwise `pcbranch=pcbranch_E`.
- `sysreg_rdata` by `sysreg_sel`. Values are zero-extended; sel 0–2 return 0 when `depth==0`.
  - 0: top ERR
  - 1: top ELR
  - 2: top ESR
  - 3: `depth`

## Timing
- Reset values (asserted, async):
  - state RUN, `depth` 0, all stack entries 0, cause 0, `overflow` 0
  - `eproc` 0, `exc_ack` 0, `evaddr_F`=VEC_BASE, `sysreg_rdata` 0, `pcbranch`=`pcbranch_E`
- Reset mid-REDIR aborts immediately; no partial state survives.
- Request sampled at edge N: push and cause latch at N; `eproc`=1 from cycle N+1 until the cycle after `exc_ack`.
- `exc_ack` asserts in the same cycle the fetch address matches; `eproc` drops at the following edge.
- `pcbranch` on `eret` is combinational in the `eret` cycle; the pop is visible from the next cycle.
- Stack top and `sysreg_rdata` reflect a push from the cycle after the accepting edge.
- Sustained (non-nesting) requests are not re-accepted until the handler ERETs.

## Test plan
- Reset; `exc_req`=4'b0100, `imem_addr_F`=0x40, `next_pc_F`=0x44, `estatus`=3:
  - `eproc` rises next cycle; `evaddr_F`=0x1D8.
  - On `imem_addr_F`=0x1D8: `exc_ack`=1, `eproc` falls.
  - `sysreg_sel`=0/1/2 read 0x44/0x40/{2,3}=0x23.
- Simultaneous `exc_req`=4'b1010 → cause 1, `evaddr_F`=0x158.
- Nesting: in a cause-2 handler, assert source 0 → push, `depth`=2. Source 3 during the same handler → ignored, `depth` unchanged.
- DEPTH=2 full, source 0 again → no push, `overflow`=1 sticky.
- ERET at `depth`=2 → `pcbranch`=inner ERR, `depth`=1. ERET with simultaneous request → pop wins; request accepted the next cycle.
- ERET at `depth`=0 → `pcbranch=pcbranch_E`. Reset asserted mid-REDIR → all outputs return to reset values at once.
